// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding, the stage
// enable/flush bundle and the default performance-counter width.
package pipe_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_RESUME = 2'd2
  } state_e;

  // Bundle order: enables from the front of the pipe to the back, then flushes.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } stage_ctrl_t;

  function automatic stage_ctrl_t ctrl_all_en(input logic ifid_fl, input logic idex_fl);
    stage_ctrl_t c;
    c            = '1;
    c.ifid_flush = ifid_fl;
    c.idex_flush = idex_fl;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Hazard requests into the sequencer and stage strobes / counters out of it.
interface pipeline_sequencer_if #(
  parameter int CNT_W = pipe_pkg::CNT_W_DEF
);
  logic             load_use_stall;
  logic             branch_taken;
  logic             jump_id;
  logic             mem_wait;
  logic             halt_req;
  logic             resume;
  logic             wb_valid;
  logic             clr_cnt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] freeze_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output load_use_stall, branch_taken, jump_id, mem_wait, halt_req, resume,
           wb_valid, clr_cnt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, cycle_cnt, stall_cnt, freeze_cnt, flush_cnt, retire_cnt
  );

  modport slave (
    input  load_use_stall, branch_taken, jump_id, mem_wait, halt_req, resume,
           wb_valid, clr_cnt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, cycle_cnt, stall_cnt, freeze_cnt, flush_cnt, retire_cnt
  );
endinterface

// File: rtl/perf_counter.sv
// Single wrapping event counter; a synchronous clear beats the increment.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush scheduler for the 5-stage pipeline: RUN/HALT/RESUME machine,
// prioritised stage strobes and the performance counters.
module pipeline_sequencer
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic        resume_q;
  stage_ctrl_t ctrl;
  stage_ctrl_t ctrl_out;

  logic st_run, st_halt, st_resume;
  logic is_freeze, is_branch, is_stall, is_jump;
  logic resume_rise;

  assign st_run    = (state_q == ST_RUN);
  assign st_halt   = (state_q == ST_HALT);
  assign st_resume = (state_q == ST_RESUME);

  // RUN priority: memory wait, then branch, then load-use, then jump.
  assign is_freeze = st_run & bus.mem_wait;
  assign is_branch = st_run & ~bus.mem_wait & bus.branch_taken;
  assign is_stall  = st_run & ~bus.mem_wait & ~bus.branch_taken & bus.load_use_stall;
  assign is_jump   = st_run & ~bus.mem_wait & ~bus.branch_taken & ~bus.load_use_stall
                     & bus.jump_id;

  assign resume_rise = bus.resume & ~resume_q;

  always_comb begin
    ctrl = ctrl_all_en(1'b0, 1'b0);
    if (st_halt || is_freeze) begin
      ctrl = '0;
    end else if (is_branch) begin
      ctrl = ctrl_all_en(1'b1, 1'b1);
    end else if (is_stall) begin
      ctrl         = ctrl_all_en(1'b0, 1'b1);
      ctrl.pc_en   = 1'b0;
      ctrl.ifid_en = 1'b0;
    end else if (is_jump) begin
      ctrl = ctrl_all_en(1'b1, 1'b0);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (bus.halt_req && !bus.mem_wait) state_d = ST_HALT;
      ST_HALT:   if (resume_rise) state_d = ST_RESUME;
      ST_RESUME: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= bus.resume;
    end
  end

  // Strobes are Mealy outputs, so reset has to mask them explicitly.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign bus.pc_en      = ctrl_out.pc_en;
  assign bus.ifid_en    = ctrl_out.ifid_en;
  assign bus.idex_en    = ctrl_out.idex_en;
  assign bus.exmem_en   = ctrl_out.exmem_en;
  assign bus.memwb_en   = ctrl_out.memwb_en;
  assign bus.ifid_flush = ctrl_out.ifid_flush;
  assign bus.idex_flush = ctrl_out.idex_flush;
  assign bus.halted     = rst_n & st_halt;

  logic cycle_inc, retire_inc;
  logic [CNT_W-1:0] cycle_c, stall_c, freeze_c, flush_c, retire_c;

  assign cycle_inc  = ~st_halt;
  // The halt instruction is held in WB and retires on the RESUME cycle.
  assign retire_inc = bus.wb_valid &
                      ((st_run & ~bus.mem_wait & ~bus.halt_req) | st_resume);

  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(cycle_inc), .clr_i(bus.clr_cnt), .cnt_o(cycle_c)
  );
  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(is_stall), .clr_i(bus.clr_cnt), .cnt_o(stall_c)
  );
  perf_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(is_freeze), .clr_i(bus.clr_cnt), .cnt_o(freeze_c)
  );
  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(is_branch | is_jump), .clr_i(bus.clr_cnt),
    .cnt_o(flush_c)
  );
  perf_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(retire_inc), .clr_i(bus.clr_cnt), .cnt_o(retire_c)
  );

  assign bus.cycle_cnt  = cycle_c;
  assign bus.stall_cnt  = stall_c;
  assign bus.freeze_cnt = freeze_c;
  assign bus.flush_cnt  = flush_c;
  assign bus.retire_cnt = retire_c;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed and random stimulus for pipeline_sequencer against a rule-level model.
module tb_pipeline_sequencer;

  localparam int CW   = 4;
  localparam int MASK = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(CW)) bus ();

  pipeline_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Reference model: plain booleans for the mode, integer event counts.
  bit          m_halt, m_resume, m_rq;
  int unsigned m_cyc, m_stall, m_freeze, m_flush, m_retire;

  task automatic model_reset();
    m_halt = 0; m_resume = 0; m_rq = 0;
    m_cyc = 0; m_stall = 0; m_freeze = 0; m_flush = 0; m_retire = 0;
  endtask

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  function automatic logic [6:0] exp_ctrl();
    if (m_halt)                 return 7'b00000_00;
    if (m_resume)               return 7'b11111_00;
    if (bus.mem_wait)           return 7'b00000_00;
    if (bus.branch_taken)       return 7'b11111_11;
    if (bus.load_use_stall)     return 7'b00111_01;
    if (bus.jump_id)            return 7'b11111_10;
    return 7'b11111_00;
  endfunction

  task automatic model_step();
    bit in_run;
    in_run = !m_halt && !m_resume;
    if (bus.clr_cnt) begin
      m_cyc = 0; m_stall = 0; m_freeze = 0; m_flush = 0; m_retire = 0;
    end else begin
      if (!m_halt) m_cyc++;
      if (in_run && bus.mem_wait) m_freeze++;
      if (in_run && !bus.mem_wait && !bus.branch_taken && bus.load_use_stall) m_stall++;
      if (in_run && !bus.mem_wait &&
          (bus.branch_taken || (!bus.load_use_stall && bus.jump_id))) m_flush++;
      if (bus.wb_valid && ((in_run && !bus.mem_wait && !bus.halt_req) || m_resume))
        m_retire++;
    end
    if (in_run) begin
      if (bus.halt_req && !bus.mem_wait) m_halt = 1;
    end else if (m_halt) begin
      if (bus.resume && !m_rq) begin m_halt = 0; m_resume = 1; end
    end else begin
      m_resume = 0;
    end
    m_rq = bus.resume;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dut_ctrl();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush};
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".ctrl"},   {25'd0, dut_ctrl()}, {25'd0, exp_ctrl()});
    check({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, m_halt});
    check({tag, ".cycle"},  {28'd0, bus.cycle_cnt},  m_cyc    & MASK);
    check({tag, ".stall"},  {28'd0, bus.stall_cnt},  m_stall  & MASK);
    check({tag, ".freeze"}, {28'd0, bus.freeze_cnt}, m_freeze & MASK);
    check({tag, ".flush"},  {28'd0, bus.flush_cnt},  m_flush  & MASK);
    check({tag, ".retire"}, {28'd0, bus.retire_cnt}, m_retire & MASK);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, ".ctrl"},   {25'd0, dut_ctrl()}, 32'd0);
    check({tag, ".halted"}, {31'd0, bus.halted}, 32'd0);
    check({tag, ".cnts"},   {12'd0, bus.cycle_cnt, bus.stall_cnt, bus.freeze_cnt,
                             bus.flush_cnt, bus.retire_cnt}, 32'd0);
  endtask

  task automatic drive(input bit lu, input bit br, input bit jp, input bit mw,
                       input bit hr, input bit rs, input bit wb, input bit clr);
    bus.load_use_stall = lu; bus.branch_taken = br; bus.jump_id = jp;
    bus.mem_wait = mw; bus.halt_req = hr; bus.resume = rs;
    bus.wb_valid = wb; bus.clr_cnt = clr;
  endtask

  // Inputs are already driven; check mid-cycle, then advance one clock.
  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_reset_zero("reset_hold");
    rst_n = 1'b1;

    step("idle");
    drive(1, 0, 0, 0, 0, 0, 0, 0); step("load_use");
    drive(0, 0, 0, 0, 0, 0, 0, 0); step("after_load_use");
    drive(1, 1, 1, 0, 0, 0, 0, 0); step("branch_beats_stall");
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("freeze_branch");
    drive(0, 1, 0, 0, 0, 0, 0, 0); step("redirect_after_freeze");
    drive(0, 0, 1, 0, 0, 0, 0, 0); step("jump");
    drive(0, 0, 1, 0, 0, 0, 1, 0); step("jump_retire");
    drive(0, 0, 0, 1, 1, 1, 1, 0); step("halt_blocked_by_wait");
    drive(0, 0, 0, 0, 1, 1, 1, 0); step("halt_entry");
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("resume_held");
    drive(0, 0, 0, 0, 0, 0, 1, 0); step("resume_low");
    drive(0, 0, 0, 0, 1, 1, 1, 0); step("resume_edge");
    drive(0, 1, 0, 0, 1, 1, 1, 0); step("resume_cycle");
    drive(0, 0, 0, 0, 0, 0, 0, 0); step("back_to_run");
    drive(1, 0, 0, 0, 0, 0, 1, 1); step("clr_with_inc");
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step("retire_wrap");
    check("retire_wrapped", {28'd0, bus.retire_cnt}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step("idle2");

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0);
      step("random");
    end

    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step("pre_reset");
    #3 rst_n = 1'b0;
    #1 check_reset_zero("async_reset");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("post_reset_idle");
    step("post_reset_idle2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central stall/flush scheduler for the 5-stage MIPS redirect pipeline.
- Takes hazard requests and produces the per-stage enable and flush strobes:
  - load-use stall from the hazard/forwarding unit
  - EX-stage branch redirect
  - ID-stage jump
  - data-memory wait
  - halt (syscall) reaching WB
- Owns the RUN/HALT/RESUME machine and the pipeline performance counters that the board display reads.

Parameters:
- CNT_W, 32, width of every performance counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- load_use_stall  in  1  load-use hazard from ID/EX compare
- branch_taken  in  1  branch resolved taken in EX
- jump_id  in  1  unconditional jump decoded in ID
- mem_wait  in  1  data memory not ready this cycle
- halt_req  in  1  halt instruction valid in WB
- resume  in  1  level from the go button, already synchronised
- wb_valid  in  1  non-bubble instruction in WB
- clr_cnt  in  1  synchronous clear of all counters
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load enables
- ifid_flush, idex_flush  out  1 each  synchronous bubble insert into IF/ID, ID/EX
- halted  out  1  state==HALT
- cycle_cnt, stall_cnt, freeze_cnt, flush_cnt, retire_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RUN, all counters 0, resume_q=0.
  - All enables, flushes and halted are forced to 0 while rst_n is low.
- States:
  - RUN: normal operation.
  - HALT: all enables and flushes are 0.
  - RESUME: one cycle, all enables are 1, no flushes, halt_req is ignored.
- Transitions:
  - RUN to HALT when halt_req=1 and mem_wait=0, taken at the clock edge. In that same cycle the RUN outputs apply with halt_req ignored, so the halt instruction stays in WB.
  - HALT to RESUME on a resume rising edge (resume=1, resume_q=0). resume_q is a register of resume, updated every cycle.
  - RESUME to RUN unconditionally.
- Stage control in RUN is combinational (Mealy), evaluated by strict priority:
  1. mem_wait: all enables 0, no flush. The whole pipe freezes; a pending branch or stall is re-evaluated next cycle.
  2. branch_taken: all enables 1, ifid_flush=1, idex_flush=1. This overrides load_use_stall and jump_id, which belong to squashed younger instructions.
  3. load_use_stall: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1.
  4. jump_id: all enables 1, ifid_flush=1.
  5. Otherwise: all enables 1, no flush.
- Flush outputs are 1-cycle strobes. A flush takes effect even if the matching enable is 1.
- Counters (registered):
  - clr_cnt has priority over every increment. All counters wrap modulo 2^CNT_W.
  - cycle_cnt: +1 every cycle when state!=HALT.
  - stall_cnt: +1 when the RUN priority resolves to case 3.
  - freeze_cnt: +1 on RUN cycles with mem_wait=1.
  - flush_cnt: +1 when the RUN priority resolves to case 2 or case 4. A branch and a jump in the same cycle count once.
  - retire_cnt: +1 when wb_valid=1 and either (state==RUN and mem_wait=0 and halt_req=0) or state==RESUME. The halt instruction is therefore counted on resume.
- A resume pulse held high through HALT entry does not cause a resume. An edge is required.

Decomposition:
- Shared package pipe_pkg:
  - state encoding: RUN=2'd0, HALT=2'd1, RESUME=2'd2
  - the stage enable/flush bundle ordering
  - CNT_W default
- Sub-module perf_counter: one CNT_W counter with inc and clr inputs. clr wins; wraps. Five instances.
- The FSM and priority logic stay in the top module.

Test Plan:
- Reset: rst_n low mid-run with counters nonzero -> all outputs 0 immediately; after release, state=RUN, counters 0, all enables 1 on the first idle cycle.
- Load-use: load_use_stall=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; stall_cnt 0 to 1.
- Branch beats stall: branch_taken=1 with load_use_stall=1 and jump_id=1 -> ifid_flush=idex_flush=1, pc_en=1; stall_cnt unchanged; flush_cnt +1 only.
- Freeze: mem_wait=1 for 3 cycles with branch_taken=1 -> all enables 0 and no flush for 3 cycles; freeze_cnt=3; the redirect fires on the 4th cycle.
- Halt/resume:
  - halt_req=1 with wb_valid=1 -> halted=1 next cycle; cycle_cnt frozen.
  - resume held high before HALT entry -> stays halted.
  - resume 0 then 1 -> one RESUME cycle with all enables 1; retire_cnt +1; back to RUN.
- Wrap/clear: CNT_W=4, 16 retiring cycles -> retire_cnt wraps to 0; clr_cnt=1 together with an increment -> counter reads 0.
